// File: rtl/code_decoder_pkg.sv
// Shared types and helpers for the registered code-to-one-hot decoder.
package code_decoder_pkg;

  localparam int unsigned CodeW = 2;
  localparam int unsigned NOut  = 2 ** CodeW;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StGap
  } dec_state_e;

  function automatic logic [NOut-1:0] onehot(input logic [CodeW-1:0] code);
    logic [NOut-1:0] res;
    res       = '0;
    res[code] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; done flags a zero count. Saturates at zero.
module hold_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/code_decoder_seq.sv
// Registered code-to-one-hot decoder with valid/ready input, programmable hold time,
// a one-cycle zero gap between patterns and a single pending slot.
module code_decoder_seq
  import code_decoder_pkg::*;
#(
  parameter int unsigned CODE_W = CodeW,
  parameter int unsigned HOLD   = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      in_code,
  output logic [2**CODE_W-1:0]   out_onehot,
  output logic                   out_valid,
  output logic                   busy,
  output logic [CNT_W-1:0]       dec_count
);

  localparam int unsigned N_OUT    = 2 ** CODE_W;
  localparam logic [7:0]  HoldLoad = 8'(HOLD - 1);

  dec_state_e        state_q;
  logic              pend_full_q;
  logic [CODE_W-1:0] pend_code_q;

  logic              accept;
  logic              timer_load;
  logic              timer_done;
  logic [CODE_W-1:0] load_code;
  logic [N_OUT-1:0]  load_pattern;

  assign in_ready = !pend_full_q;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != StIdle) || pend_full_q;

  // In GAP a waiting pending code always wins; in_ready is low then, so no conflict.
  assign load_code = (state_q == StGap && pend_full_q) ? pend_code_q : in_code;

  if (CODE_W == CodeW) begin : g_pkg_dec
    assign load_pattern = onehot(load_code);
  end else begin : g_shift_dec
    assign load_pattern = N_OUT'(1) << load_code;
  end

  always_comb begin
    timer_load = 1'b0;
    unique case (state_q)
      StIdle:  timer_load = accept;
      StGap:   timer_load = pend_full_q || accept;
      default: timer_load = 1'b0;
    endcase
  end

  hold_timer #(
    .W (8)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .en    (state_q == StHold),
    .value (HoldLoad),
    .done  (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pend_full_q <= 1'b0;
      pend_code_q <= '0;
      out_onehot  <= '0;
      out_valid   <= 1'b0;
      dec_count   <= '0;
    end else begin
      if (accept) begin
        dec_count <= dec_count + CNT_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            out_onehot <= load_pattern;
            out_valid  <= 1'b1;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (accept) begin
            pend_code_q <= in_code;
            pend_full_q <= 1'b1;
          end
          if (timer_done) begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
            state_q    <= StGap;
          end
        end
        StGap: begin
          if (pend_full_q || accept) begin
            out_onehot  <= load_pattern;
            out_valid   <= 1'b1;
            pend_full_q <= 1'b0;
            state_q     <= StHold;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          out_onehot <= '0;
          out_valid  <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_decoder_seq.sv
// Directed bench for code_decoder_seq: scoreboard of accepted codes checked against
// each emitted pattern, plus timing, ready, counter and async-reset checks.
module tb_code_decoder_seq;

  localparam int unsigned HoldA = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, busy;
  logic [1:0] in_code;
  logic [3:0] out_onehot;
  logic [7:0] dec_count;

  logic       in_valid1, in_ready1, out_valid1, busy1;
  logic [1:0] in_code1;
  logic [3:0] out_onehot1;
  logic [7:0] dec_count1;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [1:0] sb_q[$];

  logic       r1;
  int         t0;
  int         ghost;

  code_decoder_seq #(.CODE_W(2), .HOLD(HoldA), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .busy       (busy),
    .dec_count  (dec_count)
  );

  code_decoder_seq #(.CODE_W(2), .HOLD(1), .CNT_W(8)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .in_code    (in_code1),
    .out_onehot (out_onehot1),
    .out_valid  (out_valid1),
    .busy       (busy1),
    .dec_count  (dec_count1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected codes enter the scoreboard at the edge that accepts them.
  initial forever begin
    @(posedge clk);
    if (rst === 1'b0 && in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(in_code);
  end

  // Output monitor: each valid run must match the oldest accepted code, be one-hot,
  // stay constant and last exactly HoldA cycles.
  initial begin : monitor
    logic       prev_valid;
    int         run_len;
    logic [3:0] cur_pat;
    logic [3:0] exp_pat;
    logic [1:0] exp_code;
    prev_valid = 1'b0;
    run_len    = 0;
    cur_pat    = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_valid = 1'b0;
        run_len    = 0;
      end else begin
        if (out_valid === 1'b1) begin
          chk("popcount", $countones(out_onehot), 1);
          if (prev_valid !== 1'b1) begin
            if (sb_q.size() == 0) begin
              chk("unexpected_output", sb_q.size(), 1);
            end else begin
              exp_code = sb_q.pop_front();
              exp_pat  = 4'b0001 << exp_code;
              chk("pattern", out_onehot, exp_pat);
            end
            cur_pat = out_onehot;
            run_len = 1;
          end else begin
            chk("pattern_stable", out_onehot, cur_pat);
            run_len++;
          end
        end else begin
          chk("zero_when_invalid", out_onehot, 0);
          if (prev_valid === 1'b1) chk("hold_len", run_len, HoldA);
        end
        prev_valid = out_valid;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    sb_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Offer a code and return at the negedge after the edge that accepted it.
  task automatic send(input logic [1:0] c);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_code  = c;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) chk("send_timeout", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    in_valid1 = 1'b0;
    in_code1  = '0;
    #12;
    chk("rst_onehot", out_onehot, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", dec_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    #2 rst = 1'b0;

    // 1: single code in IDLE
    send(2'b10);
    in_valid = 1'b0;
    chk("t1_pat_e1", out_onehot, 4'b0100);
    chk("t1_valid_e1", out_valid, 1);
    chk("t1_count", dec_count, 1);
    tick(3);
    chk("t1_pat_e4", out_onehot, 4'b0100);
    tick(1);
    chk("t1_gap_pat", out_onehot, 0);
    chk("t1_gap_valid", out_valid, 0);
    chk("t1_gap_busy", busy, 1);
    tick(1);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_ready", in_ready, 1);

    // 2: saturated stream 0..3
    do_reset();
    send(2'd0);
    t0 = cyc;
    send(2'd1);
    chk("t2_ready_low", in_ready, 0);
    chk("t2_busy", busy, 1);
    send(2'd2);
    send(2'd3);
    in_valid = 1'b0;
    wait_idle(40);
    chk("t2_span", cyc - t0, 20);
    chk("t2_count", dec_count, 4);
    chk("t2_sb_empty", sb_q.size(), 0);

    // 3: code offered while pending is full is refused
    do_reset();
    send(2'd3);
    send(2'd1);
    in_code = 2'd2;
    chk("t3_ready_low_a", in_ready, 0);
    tick(2);
    chk("t3_ready_low_b", in_ready, 0);
    chk("t3_count_mid", dec_count, 2);
    in_valid = 1'b0;
    wait_idle(30);
    chk("t3_count", dec_count, 2);
    chk("t3_sb_empty", sb_q.size(), 0);

    // 4: HOLD=1 instance, alternating 0 and 3 streamed
    do_reset();
    in_valid1 = 1'b1;
    in_code1  = 2'd0;
    for (int i = 0; i < 8; i++) begin
      r1 = in_ready1;
      @(negedge clk);
      if (r1) in_code1 = ~in_code1;
      if (i % 2 == 1) chk("t4_gap", out_onehot1, 4'b0000);
      else chk("t4_pulse", out_onehot1, ((i / 2) % 2 == 0) ? 4'b0001 : 4'b1000);
    end
    in_valid1 = 1'b0;
    tick(4);

    // 5: asynchronous reset mid-HOLD with pending full
    do_reset();
    send(2'd2);
    send(2'd1);
    in_valid = 1'b0;
    chk("t5_pend_full", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_pat", out_onehot, 0);
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_count", dec_count, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ready", in_ready, 1);
    sb_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    ghost = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) ghost++;
    end
    chk("t5_no_ghost", ghost, 0);

    // 6: 256 accepts wrap the counter
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(2'(i * 3 + i / 4));
      if (i == 254) chk("t6_count_255", dec_count, 255);
    end
    in_valid = 1'b0;
    wait_idle(20);
    chk("t6_count_wrap", dec_count, 0);
    chk("t6_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
